// File: rtl/ws_pe_pkg.sv
// Shared types for the complement arbiter: opcodes, FSM state encoding, default width.
package ws_pe_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NEG  = 2'b01,
        OP_ABS  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef logic [0:0] state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/complement_unit.sv
// Combinational two's-complement pass/negate/abs datapath.
// COMPLEMENT_ARB_SAT_EN: overflowing negate/abs saturates to max positive instead of wrapping.
module complement_unit
    import ws_pe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] operand,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic             do_neg_s;
    logic             is_min_s;
    logic [WIDTH-1:0] neg_val_s;

    // Select between operand and its negation; flag negation of the most-negative value
    always_comb begin
        case (op)
            OP_NEG:  do_neg_s = 1'b1;
            OP_ABS:  do_neg_s = operand[WIDTH-1];
            default: do_neg_s = 1'b0;
        endcase
        is_min_s  = (operand == {1'b1, {(WIDTH-1){1'b0}}});
        neg_val_s = ~operand + WIDTH'(1);
        ovf       = do_neg_s & is_min_s;
`ifdef COMPLEMENT_ARB_SAT_EN
        if (ovf) begin
            result = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (do_neg_s) begin
            result = neg_val_s;
        end else begin
            result = operand;
        end
`else
        if (do_neg_s) begin
            result = neg_val_s;
        end else begin
            result = operand;
        end
`endif
    end

endmodule

// File: rtl/complement_arb.sv
// Round-robin arbiter feeding one shared complement unit through a single result register.
// COMPLEMENT_ARB_SAT_EN (see complement_unit) selects saturating overflow results.
module complement_arb
    import ws_pe_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]   req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_ovf
);

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [WIDTH-1:0] data_r;
    logic [IDW-1:0]   id_r;
    logic             ovf_r;

    logic             found_s;
    logic [IDW-1:0]   win_s;
    logic             grant_s;
    logic [IDW-1:0]   next_ptr_s;
    logic [WIDTH-1:0] cu_result_s;
    logic             cu_ovf_s;

    // Round-robin search starting at rr_ptr; grant only when the result register can accept
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_valid[idx]) begin
                found_s = 1'b1;
                win_s   = IDW'(idx);
            end else begin
                found_s = found_s;
            end
        end
        grant_s = found_s && !rst && ((state_r == ST_EMPTY) || rsp_ready);
        if (grant_s) begin
            req_ready = NUM_REQ'(1) << win_s;
        end else begin
            req_ready = '0;
        end
        if (win_s == IDW'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_s + IDW'(1);
        end
    end

    complement_unit #(.WIDTH(WIDTH)) u_cu (
        .operand (req_data[win_s*WIDTH +: WIDTH]),
        .op      (op_e'(req_op[win_s*2 +: 2])),
        .result  (cu_result_s),
        .ovf     (cu_ovf_s)
    );

    // Result register and EMPTY/FULL state; a grant while FULL reloads without a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_EMPTY;
            rr_ptr_r <= '0;
            data_r   <= '0;
            id_r     <= '0;
            ovf_r    <= 1'b0;
        end else if (grant_s) begin
            state_r  <= ST_FULL;
            rr_ptr_r <= next_ptr_s;
            data_r   <= cu_result_s;
            id_r     <= win_s;
            ovf_r    <= cu_ovf_s;
        end else if ((state_r == ST_FULL) && rsp_ready) begin
            state_r  <= ST_EMPTY;
        end else begin
            state_r  <= state_r;
        end
    end

    assign rsp_valid = (state_r == ST_FULL);
    assign rsp_data  = data_r;
    assign rsp_id    = id_r;
    assign rsp_ovf   = ovf_r;

endmodule

// File: tb/tb_complement_arb.sv
// Randomized + directed bench for complement_arb against a value-level reference model.
module tb_complement_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] d [4];
    logic [1:0] o [4];

    // reference model state
    bit         m_full;
    logic [7:0] m_data;
    int         m_id;
    bit         m_ovf;
    int         m_ptr;
    int         last_win;

    complement_arb #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Signed-integer view of the operation: result value, then overflow / saturation
    function automatic void ref_result(input logic [7:0] v, input logic [1:0] op,
                                       output logic [7:0] r, output bit ovf);
        int s;
        int res;
        s = v[7] ? int'(v) - 256 : int'(v);
        case (op)
            2'b01:   res = -s;
            2'b10:   res = (s < 0) ? -s : s;
            default: res = s;
        endcase
        ovf = (res > 127);
`ifdef COMPLEMENT_ARB_SAT_EN
        if (ovf) res = 127;
`endif
        r = res[7:0];
    endfunction

    task automatic step(input bit r, input logic [3:0] v, input bit rr);
        int win;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = d[i];
            req_op[i*2 +: 2]   = o[i];
        end
        #1;
        win = -1;
        if (!r && (!m_full || rr)) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            end
        end
        exp_rdy = (win < 0) ? 4'b0000 : (4'b0001 << win);
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        last_win = win;
        @(posedge clk);
        #1;
        if (r) begin
            m_full = 1'b0; m_data = 8'h00; m_id = 0; m_ovf = 1'b0; m_ptr = 0;
        end else if (win >= 0) begin
            ref_result(d[win], o[win], m_data, m_ovf);
            m_id   = win;
            m_full = 1'b1;
            m_ptr  = (win + 1) % 4;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
        if (m_full || r) begin
            check("rsp_data", {24'd0, rsp_data}, {24'd0, m_data});
            check("rsp_id",   {30'd0, rsp_id},   m_id);
            check("rsp_ovf",  {31'd0, rsp_ovf},  {31'd0, m_ovf});
        end
    endtask

    task automatic set_all(input logic [7:0] dv, input logic [1:0] ov);
        for (int i = 0; i < 4; i++) begin d[i] = dv; o[i] = ov; end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_data = '0; req_op = '0;
        m_full = 1'b0; m_data = 8'h00; m_id = 0; m_ovf = 1'b0; m_ptr = 0; last_win = -1;
        set_all(8'h00, 2'b00);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b1);

        // single requester negate
        d[0] = 8'h05; o[0] = 2'b01;
        step(1'b0, 4'b0001, 1'b1);
        check("neg5_grant", {31'd0, (last_win == 0)}, 32'd1);
        check("neg5_data", {24'd0, rsp_data}, 32'hFB);
        step(1'b0, 4'b0000, 1'b1);

        // all valid continuously: 0,1,2,3,0 back to back
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin d[i] = 8'h20 + 8'(i); o[i] = 2'b00; end
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 4'b1111, 1'b1);
            check("rr_order", last_win, n % 4);
            check("no_bubble", {31'd0, rsp_valid}, 32'd1);
        end

        // backpressure: hold 0x10 while requester 2 waits
        step(1'b1, 4'b0000, 1'b0);
        d[0] = 8'h10; o[0] = 2'b00; d[2] = 8'h33; o[2] = 2'b01;
        step(1'b0, 4'b0001, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 4'b0100, 1'b0);
            check("bp_hold", {24'd0, rsp_data}, 32'h10);
        end
        step(1'b0, 4'b0100, 1'b1);
        check("bp_grant2", last_win, 2);
        check("bp_next", {24'd0, rsp_data}, 32'hCD);

        // abs corner cases and reserved opcode
        d[3] = 8'h80; o[3] = 2'b10;
        step(1'b0, 4'b1000, 1'b1);
`ifdef COMPLEMENT_ARB_SAT_EN
        check("abs80", {24'd0, rsp_data}, 32'h7F);
`else
        check("abs80", {24'd0, rsp_data}, 32'h80);
`endif
        check("abs80_ovf", {31'd0, rsp_ovf}, 32'd1);
        d[0] = 8'h85; o[0] = 2'b10;
        step(1'b0, 4'b0001, 1'b1);
        check("abs85", {24'd0, rsp_data}, 32'h7B);
        check("abs85_ovf", {31'd0, rsp_ovf}, 32'd0);
        d[1] = 8'hC3; o[1] = 2'b11;
        step(1'b0, 4'b0010, 1'b1);
        check("rsvd", {24'd0, rsp_data}, 32'hC3);
        check("rsvd_ovf", {31'd0, rsp_ovf}, 32'd0);

        // reset while FULL, then requester 0 must win over 1
        d[1] = 8'h44; o[1] = 2'b00;
        step(1'b0, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ptr", {30'd0, dut.rr_ptr_r}, 32'd0);
        d[0] = 8'h01; o[0] = 2'b01;
        step(1'b0, 4'b0011, 1'b1);
        check("rst_win0", last_win, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                d[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                o[i] = 2'($urandom);
            end
            step(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
